bot_feeder: RTL and testbench

BOT_FEEDER -- requirements
Module: bot_feeder

---
 rtl/bot_feeder.sv | 147 ++++++++++++++
 tb/tb_bot_feeder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bot_feeder.sv
//==============================================================================
// Module   : bot_feeder
// Brief    : Feeds the bot stream of one top to the 24-permutation pack with
//            fullness back-pressure, then flushes before retiring the top.
//            Define BOT_FEEDER_STATS_EN to build the stall counter; the
//            ADDR_WIDTH macro sets the default botIndex width.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module bot_feeder #(
    parameter int          ADDR_WIDTH     = `ADDR_WIDTH,
    parameter int unsigned FULLNESS_LIMIT = 20,
    parameter int unsigned FLUSH_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [127:0]          topIn,
    input  logic                  topInValid,
    output logic                  topInReady,
    input  logic [127:0]          botIn,
    input  logic                  botInValid,
    output logic                  botInReady,
    input  logic                  botInLast,
    input  logic [4:0]            maxFullness,
    output logic [127:0]          top,
    output logic [127:0]          bot,
    output logic [ADDR_WIDTH-1:0] botIndex,
    output logic                  isBotValid,
    output logic                  topDone,
    output logic [31:0]           stallCycles
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam int                 c_CNT_W      = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_FLUSH_LOAD = c_CNT_W'(FLUSH_CYCLES);

    logic [1:0]            r_state;
    logic [127:0]          r_top;
    logic [127:0]          r_bot;
    logic [ADDR_WIDTH-1:0] r_botIndex;
    logic [ADDR_WIDTH-1:0] r_nextIndex;
    logic                  r_isBotValid;
    logic                  r_topDone;
    logic [c_CNT_W-1:0]    r_flushCount;

    logic w_botInReady;
    logic w_transfer;
    logic w_topLoad;

    assign w_botInReady = (r_state == c_RUN) && (32'(maxFullness) < FULLNESS_LIMIT);
    assign w_transfer   = botInValid && w_botInReady;
    assign w_topLoad    = (r_state == c_IDLE) && topInValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_top        <= '0;
            r_bot        <= '0;
            r_botIndex   <= '0;
            r_nextIndex  <= '0;
            r_isBotValid <= 1'b0;
            r_topDone    <= 1'b0;
            r_flushCount <= '0;
        end else begin
            r_isBotValid <= 1'b0;
            r_topDone    <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_topLoad) begin
                        r_top       <= topIn;
                        r_botIndex  <= '0;
                        r_nextIndex <= '0;
                        r_state     <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (w_transfer) begin
                        r_bot        <= botIn;
                        r_isBotValid <= 1'b1;
                        r_botIndex   <= r_nextIndex;
                        r_nextIndex  <= r_nextIndex + ADDR_WIDTH'(1);
                        if (botInLast) begin
                            r_state      <= c_FLUSH;
                            r_flushCount <= c_FLUSH_LOAD;
                        end
                    end
                end
                c_FLUSH: begin
                    // The pack must also be drained before the top may retire.
                    if (r_flushCount != '0) begin
                        r_flushCount <= r_flushCount - c_CNT_W'(1);
                    end else if (maxFullness == 5'd0) begin
                        r_state   <= c_DONE;
                        r_topDone <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign topInReady = (r_state == c_IDLE);
    assign botInReady = w_botInReady;
    assign top        = r_top;
    assign bot        = r_bot;
    assign botIndex   = r_botIndex;
    assign isBotValid = r_isBotValid;
    assign topDone    = r_topDone;

`ifdef BOT_FEEDER_STATS_EN
    logic [31:0] r_stallCycles;
    logic        w_stallEvent;

    assign w_stallEvent = (r_state == c_RUN) && botInValid && !w_botInReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles <= '0;
        end else if (w_topLoad) begin
            r_stallCycles <= '0;
        end else if (w_stallEvent && (r_stallCycles != 32'hFFFF_FFFF)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign stallCycles = r_stallCycles;
`else
    assign stallCycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bot_feeder.sv
//==============================================================================
// Module   : tb_bot_feeder
// Brief    : Self-checking bench for bot_feeder (default and 3-bit index builds).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bot_feeder;

    localparam int FLUSH = 16;
`ifdef BOT_FEEDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] topIn = '0;
    logic [127:0] botIn = '0;
    logic         topInValid = 1'b0;
    logic         botInValid = 1'b0;
    logic         botInLast = 1'b0;
    logic [4:0]   maxFullness = '0;

    logic         topInReady, botInReady, isBotValid, topDone;
    logic [127:0] top, bot;
    logic [7:0]   botIndex;
    logic [31:0]  stallCycles;

    logic         w3TopInReady, w3BotInReady, w3IsBotValid, w3TopDone;
    logic [127:0] w3Top, w3Bot;
    logic [2:0]   w3BotIndex;
    logic [31:0]  w3StallCycles;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    bot_feeder #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .topIn(topIn), .topInValid(topInValid), .topInReady(topInReady),
        .botIn(botIn), .botInValid(botInValid), .botInReady(botInReady), .botInLast(botInLast),
        .maxFullness(maxFullness),
        .top(top), .bot(bot), .botIndex(botIndex), .isBotValid(isBotValid),
        .topDone(topDone), .stallCycles(stallCycles)
    );

    bot_feeder #(.ADDR_WIDTH(3)) dutW3 (
        .clk(clk), .rst(rst),
        .topIn(topIn), .topInValid(topInValid), .topInReady(w3TopInReady),
        .botIn(botIn), .botInValid(botInValid), .botInReady(w3BotInReady), .botInLast(botInLast),
        .maxFullness(maxFullness),
        .top(w3Top), .bot(w3Bot), .botIndex(w3BotIndex), .isBotValid(w3IsBotValid),
        .topDone(w3TopDone), .stallCycles(w3StallCycles)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadTop(input logic [127:0] t);
        int n = 0;
        while (!topInReady && n < 100) begin
            tick();
            n++;
        end
        chk("load_ready", 128'(topInReady), 128'(1));
        topIn = t;
        topInValid = 1'b1;
        tick();
        topInValid = 1'b0;
    endtask

    task automatic sendBot(input logic [127:0] d, input logic last);
        int n = 0;
        botIn = d;
        botInLast = last;
        botInValid = 1'b1;
        #1;
        while (!botInReady && n < 200) begin
            tick();
            #1;
            n++;
        end
        chk("send_ready", 128'(botInReady), 128'(1));
        tick();
        botInValid = 1'b0;
        botInLast = 1'b0;
    endtask

    task automatic waitDone(input string name, output int n);
        n = 0;
        while (!topDone && n < 300) begin
            tick();
            n++;
        end
        chk(name, 128'(topDone), 128'(1));
    endtask

    // Reference model: expected registered outputs follow from the bench's own
    // view of the handshake rules, tracked with flags and cycle timestamps.
    logic [127:0] eTop = '0, eBot = '0;
    logic [31:0]  eStall = '0;
    int           eIdx = 0, mCount = 0, cyc = 0, mLastCyc = 0;
    bit           eValid = 0, eDone = 0, mHave = 0, mLast = 0, mDoneNow = 0;

    initial begin : monitor
        bit eTopRdy, eBotRdy;
        forever begin
            @(negedge clk);
            eTopRdy = !mHave && !mDoneNow;
            eBotRdy = mHave && !mLast && (maxFullness < 5'd20);
            chk("mon_top", top, eTop);
            chk("mon_bot", bot, eBot);
            chk("mon_idx", 128'(botIndex), 128'(eIdx % 256));
            chk("mon_valid", 128'(isBotValid), 128'(eValid));
            chk("mon_done", 128'(topDone), 128'(eDone));
            chk("mon_stall", 128'(stallCycles), 128'(STATS ? eStall : 32'd0));
            chk("mon_topRdy", 128'(topInReady), 128'(eTopRdy));
            chk("mon_botRdy", 128'(botInReady), 128'(eBotRdy));
            chk("mon_w3_top", w3Top, eTop);
            chk("mon_w3_bot", w3Bot, eBot);
            chk("mon_w3_idx", 128'(w3BotIndex), 128'(eIdx % 8));
            chk("mon_w3_valid", 128'(w3IsBotValid), 128'(eValid));
            chk("mon_w3_done", 128'(w3TopDone), 128'(eDone));
            chk("mon_w3_stall", 128'(w3StallCycles), 128'(STATS ? eStall : 32'd0));
            chk("mon_w3_rdy", 128'({w3TopInReady, w3BotInReady}), 128'({eTopRdy, eBotRdy}));

            eValid = 0;
            eDone = 0;
            if (rst) begin
                eTop = '0; eBot = '0; eIdx = 0; eStall = '0;
                mHave = 0; mLast = 0; mDoneNow = 0;
            end else if (mDoneNow) begin
                mDoneNow = 0;
            end else if (!mHave) begin
                if (topInValid) begin
                    eTop = topIn; eIdx = 0; mCount = 0; eStall = '0;
                    mHave = 1; mLast = 0;
                end
            end else if (!mLast) begin
                if (botInValid && maxFullness < 5'd20) begin
                    eBot = botIn; eValid = 1; eIdx = mCount; mCount++;
                    if (botInLast) begin
                        mLast = 1;
                        mLastCyc = cyc;
                    end
                end else if (botInValid && eStall != 32'hFFFF_FFFF) begin
                    eStall++;
                end
            end else if (cyc >= mLastCyc + FLUSH + 1 && maxFullness == 5'd0) begin
                // Counter reaches zero FLUSH+1 cycles after the last transfer.
                eDone = 1; mDoneNow = 1; mHave = 0;
            end
            cyc++;
        end
    end

    typedef struct {
        logic [4:0] mf;
        logic       valid;
        logic       expReady;
        logic       expIssue;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t         vecs[8];
        logic [127:0] d, t1, t2;
        int           n, bad, idx;
        bit           seen;

        vecs[0] = '{5'd0,  1'b1, 1'b1, 1'b1};
        vecs[1] = '{5'd19, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{5'd20, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{5'd21, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{5'd31, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{5'd1,  1'b0, 1'b1, 1'b0};
        vecs[6] = '{5'd20, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{5'd10, 1'b1, 1'b1, 1'b1};

        // Reset values, and bots ignored in IDLE.
        repeat (3) tick();
        botInValid = 1'b1;
        #1;
        chk("rst_top", top, 128'(0));
        chk("rst_bot", bot, 128'(0));
        chk("rst_idx", 128'(botIndex), 128'(0));
        chk("rst_valid", 128'(isBotValid), 128'(0));
        chk("rst_done", 128'(topDone), 128'(0));
        chk("rst_stall", 128'(stallCycles), 128'(0));
        chk("rst_topRdy", 128'(topInReady), 128'(1));
        chk("rst_botRdy", 128'(botInReady), 128'(0));
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_ignore", 128'(isBotValid), 128'(0));
        botInValid = 1'b0;

        // Four bots back to back, topDone 17 cycles after the last issue.
        t1 = {16{8'hA5}};
        loadTop(t1);
        chk("a5_top", top, t1);
        maxFullness = 5'd0;
        for (int i = 0; i < 4; i++) begin
            d = rnd128();
            botIn = d; botInValid = 1'b1; botInLast = (i == 3);
            tick();
            chk("a5_valid", 128'(isBotValid), 128'(1));
            chk("a5_idx", 128'(botIndex), 128'(i));
            chk("a5_bot", bot, d);
        end
        botInValid = 1'b0; botInLast = 1'b0;
        waitDone("a5_done", n);
        chk("a5_done_latency", 128'(n), 128'(17));
        chk("a5_top_stable", top, t1);
        tick();
        chk("a5_done_pulse", 128'(topDone), 128'(0));

        // Table-driven fullness/valid vectors in RUN.
        loadTop(rnd128());
        idx = 0;
        foreach (vecs[k]) begin
            d = rnd128();
            maxFullness = vecs[k].mf; botInValid = vecs[k].valid; botIn = d;
            #1;
            chk("vec_ready", 128'(botInReady), 128'(vecs[k].expReady));
            tick();
            chk("vec_issue", 128'(isBotValid), 128'(vecs[k].expIssue));
            if (vecs[k].expIssue) begin
                chk("vec_bot", bot, d);
                chk("vec_idx", 128'(botIndex), 128'(idx));
                idx++;
            end
        end
        botInValid = 1'b0; maxFullness = 5'd0;
        sendBot(rnd128(), 1'b1);
        waitDone("vec_done", n);

        // Five stall cycles at the limit, then release one below it.
        loadTop(rnd128());
        d = rnd128();
        maxFullness = 5'd20; botInValid = 1'b1; botIn = d;
        bad = 0;
        repeat (5) begin
            #1;
            if (botInReady) bad++;
            tick();
            if (isBotValid) bad++;
        end
        chk("stall_blocked", 128'(bad), 128'(0));
        chk("stall_count", 128'(stallCycles), 128'(STATS ? 32'd5 : 32'd0));
        maxFullness = 5'd19;
        tick();
        botInValid = 1'b0;
        chk("stall_release", 128'(isBotValid), 128'(1));
        chk("stall_bot", bot, d);
        maxFullness = 5'd0;
        sendBot(rnd128(), 1'b1);
        waitDone("stall_done", n);

        // Flush held open by a nonzero fullness.
        loadTop(rnd128());
        sendBot(rnd128(), 1'b1);
        chk("single_idx", 128'(botIndex), 128'(0));
        maxFullness = 5'd3;
        seen = 0;
        repeat (40) begin
            tick();
            seen |= topDone;
        end
        chk("flush_held", 128'(seen), 128'(0));
        maxFullness = 5'd0;
        tick();
        chk("flush_release", 128'(topDone), 128'(1));
        tick();
        chk("flush_pulse", 128'(topDone), 128'(0));

        // Ten bots: 3-bit index wraps.
        loadTop(rnd128());
        for (int i = 0; i < 10; i++) begin
            botIn = rnd128(); botInValid = 1'b1; botInLast = (i == 9);
            tick();
            chk("wrap_idx8", 128'(botIndex), 128'(i));
            chk("wrap_idx3", 128'(w3BotIndex), 128'(i % 8));
        end
        botInValid = 1'b0; botInLast = 1'b0;
        waitDone("wrap_done", n);

        // Reset on the second RUN cycle beats concurrent handshakes.
        loadTop(rnd128());
        botIn = rnd128(); botInValid = 1'b1;
        tick();
        rst = 1'b1; topInValid = 1'b1; topIn = rnd128();
        tick();
        chk("midrst_valid", 128'(isBotValid), 128'(0));
        chk("midrst_topRdy", 128'(topInReady), 128'(1));
        chk("midrst_top", top, 128'(0));
        chk("midrst_idx", 128'(botIndex), 128'(0));
        rst = 1'b0; topInValid = 1'b0; botInValid = 1'b0;
        seen = 0;
        repeat (30) begin
            tick();
            seen |= topDone;
        end
        chk("midrst_no_done", 128'(seen), 128'(0));

        // Handshakes held through FLUSH and DONE are ignored.
        t1 = rnd128(); t2 = rnd128();
        loadTop(t1);
        sendBot(rnd128(), 1'b1);
        topInValid = 1'b1; topIn = t2; botInValid = 1'b1; botIn = rnd128();
        n = 0; bad = 0;
        while (!topDone && n < 100) begin
            tick();
            n++;
            if (isBotValid || top !== t1) bad++;
        end
        chk("hold_len", 128'(n), 128'(17));
        chk("hold_ignored", 128'(bad), 128'(0));
        chk("hold_done_topRdy", 128'(topInReady), 128'(0));
        tick();
        chk("hold_idle_top", top, t1);
        chk("hold_idle_rdy", 128'(topInReady), 128'(1));
        tick();
        chk("hold_load", top, t2);
        topInValid = 1'b0; botInValid = 1'b0;
        sendBot(rnd128(), 1'b1);
        waitDone("hold_done2", n);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 25; k++) begin
            int nb, sent, guard;
            loadTop(rnd128());
            nb = $urandom_range(1, 12);
            sent = 0; guard = 0;
            while (sent < nb && guard < 2000) begin
                maxFullness = 5'($urandom_range(0, 24));
                botInValid = ($urandom_range(0, 3) != 0);
                botIn = rnd128();
                botInLast = (sent == nb - 1);
                topInValid = $urandom_range(0, 1) != 0;
                topIn = rnd128();
                #1;
                if (botInValid && botInReady) sent++;
                tick();
                guard++;
            end
            chk("rand_sent", 128'(sent), 128'(nb));
            topInValid = 1'b0; botInLast = 1'b0;
            n = 0;
            while (!topDone && n < 1000) begin
                maxFullness = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
                botInValid = $urandom_range(0, 1) != 0;
                tick();
                n++;
            end
            chk("rand_done", 128'(topDone), 128'(1));
            maxFullness = 5'd0; botInValid = 1'b0;
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

`default_nettype wire
